// File: rtl/riscv_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder/loader.
package riscv_enc_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned FMT_W = 3;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned REG_W = 5;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned F7_W  = 7;
    localparam int unsigned ERR_W = 2;

    // Instruction formats; codes 6 and 7 are illegal
    typedef enum logic [FMT_W-1:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef enum logic [ERR_W-1:0] {
        ERR_NONE   = 2'd0,
        ERR_RANGE  = 2'd1,
        ERR_ALIGN  = 2'd2,
        ERR_FORMAT = 2'd3
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENCODE = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FULL   = 2'd3
    } state_e;

    // RV32I base opcodes
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

    // Captured instruction fields
    typedef struct packed {
        logic [FMT_W-1:0] fmt;
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [F3_W-1:0]  funct3;
        logic [F7_W-1:0]  funct7;
        logic [XLEN-1:0]  imm;
    } fields_t;

    // True when bits [31:lsb] of v are all ones or all zeros (sign-extension holds)
    function automatic logic upper_uniform(input logic [XLEN-1:0] v, input int unsigned lsb);
        logic [XLEN-1:0] mask;
        mask = {XLEN{1'b1}} << lsb;
        return ((v & mask) == mask) || ((v & mask) == '0);
    endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational immediate check and RV32I field packer.
module inst_pack
    import riscv_enc_pkg::*;
(
    input  fields_t          fields,
    output logic [XLEN-1:0]  word_c,
    output logic             err_c,
    output logic [ERR_W-1:0] err_code_c
);

    logic [XLEN-1:0] imm;
    err_e            code;

    assign imm = fields.imm;

    // Check priority: bad format, then misalignment, then range
    always_comb begin
        word_c = '0;
        code   = ERR_NONE;
        case (fields.fmt)
            FMT_R: begin
                word_c = {fields.funct7, fields.rs2, fields.rs1, fields.funct3,
                          fields.rd, fields.opcode};
            end
            FMT_I: begin
                if (!upper_uniform(imm, 11)) code = ERR_RANGE;
                word_c = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
            end
            FMT_S: begin
                if (!upper_uniform(imm, 11)) code = ERR_RANGE;
                word_c = {imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                          imm[4:0], fields.opcode};
            end
            FMT_B: begin
                if (imm[0])                       code = ERR_ALIGN;
                else if (!upper_uniform(imm, 12)) code = ERR_RANGE;
                word_c = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                          imm[4:1], imm[11], fields.opcode};
            end
            FMT_U: begin
                if (imm[11:0] != 12'd0) code = ERR_RANGE;
                word_c = {imm[31:12], fields.rd, fields.opcode};
            end
            FMT_J: begin
                if (imm[0])                       code = ERR_ALIGN;
                else if (!upper_uniform(imm, 20)) code = ERR_RANGE;
                word_c = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd, fields.opcode};
            end
            default: code = ERR_FORMAT;
        endcase
    end

    assign err_c      = (code != ERR_NONE);
    assign err_code_c = code;

endmodule

// File: rtl/inst_encoder_loader.sv
// Encodes RV32I fields into instruction words and writes them to sequential addresses.
module inst_encoder_loader
    import riscv_enc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
)(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [FMT_W-1:0]    format_i,
    input  logic [OPC_W-1:0]    opcode_i,
    input  logic [REG_W-1:0]    rd_i,
    input  logic [REG_W-1:0]    rs1_i,
    input  logic [REG_W-1:0]    rs2_i,
    input  logic [F3_W-1:0]     funct3_i,
    input  logic [F7_W-1:0]     funct7_i,
    input  logic [XLEN-1:0]     imm_i,
    output logic                wr_en_o,
    output logic [ADDR_W-1:0]   wr_addr_o,
    output logic [XLEN-1:0]     wr_data_o,
    output logic                err_o,
    output logic [ERR_W-1:0]    err_code_o,
    output logic [ADDR_W:0]     count_o,
    output logic                full_o
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_e              state_q, state_d;
    fields_t             fields_q, fields_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                full_q, full_d;
    logic                wr_en_q, wr_en_d;
    logic [XLEN-1:0]     wr_data_q, wr_data_d;
    logic                err_q, err_d;
    logic [ERR_W-1:0]    err_code_q, err_code_d;

    logic [XLEN-1:0]     pack_word_c;
    logic                pack_err_c;
    logic [ERR_W-1:0]    pack_code_c;

    inst_pack u_pack (
        .fields     (fields_q),
        .word_c     (pack_word_c),
        .err_c      (pack_err_c),
        .err_code_c (pack_code_c)
    );

    // Next-state and next-register values; start_i overrides everything
    always_comb begin
        state_d    = state_q;
        fields_d   = fields_q;
        addr_d     = addr_q;
        count_d    = count_q;
        full_d     = full_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        if (start_i) begin
            state_d = ST_IDLE;
            addr_d  = BASE;
            count_d = '0;
            full_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (valid_i) begin
                        fields_d.fmt    = format_i;
                        fields_d.opcode = opcode_i;
                        fields_d.rd     = rd_i;
                        fields_d.rs1    = rs1_i;
                        fields_d.rs2    = rs2_i;
                        fields_d.funct3 = funct3_i;
                        fields_d.funct7 = funct7_i;
                        fields_d.imm    = imm_i;
                        state_d         = ST_ENCODE;
                    end
                end
                ST_ENCODE: begin
                    if (pack_err_c) begin
                        err_d      = 1'b1;
                        err_code_d = pack_code_c;
                        state_d    = ST_IDLE;
                    end else begin
                        wr_data_d = pack_word_c;
                        wr_en_d   = 1'b1;
                        state_d   = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    addr_d  = addr_q + ADDR_W'(1);
                    count_d = count_q + CNT_W'(1);
                    if (&addr_q) begin
                        full_d  = 1'b1;
                        state_d = ST_FULL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FULL: state_d = ST_FULL;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            fields_q   <= '0;
            addr_q     <= BASE;
            count_q    <= '0;
            full_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            fields_q   <= fields_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // A restart request in the same cycle blocks acceptance
    assign ready_o    = (state_q == ST_IDLE) && !start_i;
    assign wr_en_o    = wr_en_q;
    assign wr_addr_o  = addr_q;
    assign wr_data_o  = wr_data_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;
    assign count_o    = count_q;
    assign full_o     = full_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Bench: two loaders (8-bit and 2-bit address) share one stimulus stream and are
// checked every cycle against a transaction-level reference model.
module tb_inst_encoder_loader;
    import riscv_enc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic [2:0]  fmt = '0;
    logic [6:0]  op = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]  f3 = '0;
    logic [6:0]  f7 = '0;
    logic [31:0] imm = '0;

    logic        b_ready, b_wr_en, b_err, b_full;
    logic [7:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic [1:0]  b_code;
    logic [8:0]  b_count;

    logic        s_ready, s_wr_en, s_err, s_full;
    logic [1:0]  s_wr_addr;
    logic [31:0] s_wr_data;
    logic [1:0]  s_code;
    logic [2:0]  s_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut_big (
        .clk_i(clk), .rst_i(rst), .start_i(start), .valid_i(valid), .ready_o(b_ready),
        .format_i(fmt), .opcode_i(op), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
        .funct3_i(f3), .funct7_i(f7), .imm_i(imm),
        .wr_en_o(b_wr_en), .wr_addr_o(b_wr_addr), .wr_data_o(b_wr_data),
        .err_o(b_err), .err_code_o(b_code), .count_o(b_count), .full_o(b_full)
    );

    inst_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
        .clk_i(clk), .rst_i(rst), .start_i(start), .valid_i(valid), .ready_o(s_ready),
        .format_i(fmt), .opcode_i(op), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
        .funct3_i(f3), .funct7_i(f7), .imm_i(imm),
        .wr_en_o(s_wr_en), .wr_addr_o(s_wr_addr), .wr_data_o(s_wr_data),
        .err_o(s_err), .err_code_o(s_code), .count_o(s_count), .full_o(s_full)
    );

    // Reference encoder: returns {error_code, word} from plain arithmetic on the immediate
    function automatic logic [33:0] ref_enc(input int f, input logic [6:0] o, input logic [4:0] d,
                                            input logic [4:0] a, input logic [4:0] b,
                                            input logic [2:0] g3, input logic [6:0] g7,
                                            input logic [31:0] v);
        longint s;
        logic [31:0] w;
        int code;
        s = longint'($signed(v));
        w = '0;
        code = 0;
        case (f)
            0: w = (32'(g7) << 25) | (32'(b) << 20) | (32'(a) << 15) | (32'(g3) << 12)
                   | (32'(d) << 7) | 32'(o);
            1: begin
                if (s < -2048 || s > 2047) code = 1;
                w = ((v & 32'hFFF) << 20) | (32'(a) << 15) | (32'(g3) << 12) | (32'(d) << 7) | 32'(o);
            end
            2: begin
                if (s < -2048 || s > 2047) code = 1;
                w = (((v >> 5) & 32'h7F) << 25) | (32'(b) << 20) | (32'(a) << 15)
                    | (32'(g3) << 12) | ((v & 32'h1F) << 7) | 32'(o);
            end
            3: begin
                if ((v & 32'h1) != 0) code = 2;
                else if (s < -4096 || s > 4095) code = 1;
                w = (((v >> 12) & 32'h1) << 31) | (((v >> 5) & 32'h3F) << 25) | (32'(b) << 20)
                    | (32'(a) << 15) | (32'(g3) << 12) | (((v >> 1) & 32'hF) << 8)
                    | (((v >> 11) & 32'h1) << 7) | 32'(o);
            end
            4: begin
                if ((v & 32'hFFF) != 0) code = 1;
                w = (v & 32'hFFFF_F000) | (32'(d) << 7) | 32'(o);
            end
            5: begin
                if ((v & 32'h1) != 0) code = 2;
                else if (s < -1048576 || s > 1048575) code = 1;
                w = (((v >> 20) & 32'h1) << 31) | (((v >> 1) & 32'h3FF) << 21)
                    | (((v >> 11) & 32'h1) << 20) | (((v >> 12) & 32'hFF) << 12)
                    | (32'(d) << 7) | 32'(o);
            end
            default: code = 3;
        endcase
        return {2'(code), w};
    endfunction

    // Model state per loader: index 0 = 8-bit address, 1 = 2-bit address.
    // m_age: -1 no transaction, 1 = cycle after acceptance, 2 = write cycle.
    int          m_aw[2]      = '{8, 2};
    int          m_addr[2]    = '{0, 0};
    int          m_count[2]   = '{0, 0};
    bit          m_full[2]    = '{0, 0};
    int          m_age[2]     = '{-1, -1};
    logic [33:0] m_res[2]     = '{34'd0, 34'd0};
    bit          m_wr_en[2]   = '{0, 0};
    logic [31:0] m_wr_data[2] = '{32'd0, 32'd0};
    bit          m_err[2]     = '{0, 0};
    int          m_code[2]    = '{0, 0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_addr[k] = 0; m_count[k] = 0; m_full[k] = 0; m_age[k] = -1;
                m_wr_en[k] = 0; m_wr_data[k] = '0; m_err[k] = 0; m_code[k] = 0;
            end else if (start) begin
                m_addr[k] = 0; m_count[k] = 0; m_full[k] = 0; m_age[k] = -1;
                m_wr_en[k] = 0; m_err[k] = 0;
            end else begin
                m_wr_en[k] = 0;
                m_err[k] = 0;
                if (m_age[k] == 1) begin
                    if (m_res[k][33:32] != 2'd0) begin
                        m_err[k] = 1;
                        m_code[k] = int'(m_res[k][33:32]);
                        m_age[k] = -1;
                    end else begin
                        m_wr_en[k] = 1;
                        m_wr_data[k] = m_res[k][31:0];
                        m_age[k] = 2;
                    end
                end else if (m_age[k] == 2) begin
                    if (m_addr[k] == (1 << m_aw[k]) - 1) m_full[k] = 1;
                    m_addr[k] = (m_addr[k] + 1) % (1 << m_aw[k]);
                    m_count[k]++;
                    m_age[k] = -1;
                end else if (valid && !m_full[k]) begin
                    m_res[k] = ref_enc(int'(fmt), op, rd, rs1, rs2, f3, f7, imm);
                    m_age[k] = 1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [63:0] e_ready;
        for (int k = 0; k < 2; k++) begin
            e_ready = 64'((m_age[k] == -1) && !m_full[k] && !start);
            if (k == 0) begin
                chk("big.ready",    64'(b_ready),   e_ready);
                chk("big.wr_en",    64'(b_wr_en),   64'(m_wr_en[k]));
                chk("big.wr_addr",  64'(b_wr_addr), 64'(m_addr[k]));
                chk("big.wr_data",  64'(b_wr_data), 64'(m_wr_data[k]));
                chk("big.err",      64'(b_err),     64'(m_err[k]));
                chk("big.err_code", 64'(b_code),    64'(m_code[k]));
                chk("big.count",    64'(b_count),   64'(m_count[k]));
                chk("big.full",     64'(b_full),    64'(m_full[k]));
            end else begin
                chk("small.ready",    64'(s_ready),   e_ready);
                chk("small.wr_en",    64'(s_wr_en),   64'(m_wr_en[k]));
                chk("small.wr_addr",  64'(s_wr_addr), 64'(m_addr[k]));
                chk("small.wr_data",  64'(s_wr_data), 64'(m_wr_data[k]));
                chk("small.err",      64'(s_err),     64'(m_err[k]));
                chk("small.err_code", 64'(s_code),    64'(m_code[k]));
                chk("small.count",    64'(s_count),   64'(m_count[k]));
                chk("small.full",     64'(s_full),    64'(m_full[k]));
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_fields(input logic [2:0] f, input logic [6:0] o, input logic [4:0] d,
                              input logic [4:0] a, input logic [4:0] b, input logic [2:0] g3,
                              input logic [31:0] v);
        fmt = f; op = o; rd = d; rs1 = a; rs2 = b; f3 = g3; f7 = 7'd0; imm = v;
    endtask

    // Present one transfer and return in the C2 cycle (outputs of the encode step visible)
    task automatic xfer();
        valid = 1'b1;
        cycle();
        valid = 1'b0;
        cycle();
    endtask

    initial begin
        // Pin the reference encoder to hand-computed words and codes
        chk("ref.I",     64'(ref_enc(1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF)), 64'h0_FFF00093);
        chk("ref.B",     64'(ref_enc(3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC)), 64'h0_FE208EE3);
        chk("ref.U",     64'(ref_enc(4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000)), 64'h0_123452B7);
        chk("ref.Jodd",  64'(ref_enc(5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3) >> 32), 64'd2);
        chk("ref.Jbig",  64'(ref_enc(5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000) >> 32), 64'd1);
        chk("ref.fmt6",  64'(ref_enc(6, 7'b0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0) >> 32), 64'd3);
        chk("ref.I2048", 64'(ref_enc(1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048) >> 32), 64'd1);

        // Reset and release
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        chk("reset.ready", 64'(b_ready), 64'd1);
        chk("reset.wr_en", 64'(b_wr_en), 64'd0);
        chk("reset.addr",  64'(b_wr_addr), 64'd0);
        chk("reset.count", 64'(b_count), 64'd0);
        chk("reset.full",  64'(b_full), 64'd0);

        // I-type addi x1, x0, -1
        set_fields(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF);
        xfer();
        chk("I.wr_en", 64'(b_wr_en), 64'd1);
        chk("I.addr",  64'(b_wr_addr), 64'd0);
        chk("I.data",  64'(b_wr_data), 64'hFFF00093);
        cycle();
        chk("I.count", 64'(b_count), 64'd1);
        chk("I.ready", 64'(b_ready), 64'd1);

        // B-type beq x1, x2, -4
        set_fields(FMT_B, OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFFC);
        xfer();
        chk("B.addr", 64'(b_wr_addr), 64'd1);
        chk("B.data", 64'(b_wr_data), 64'hFE208EE3);
        cycle();

        // U-type lui x5, 0x12345
        set_fields(FMT_U, OPC_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
        xfer();
        chk("U.data", 64'(b_wr_data), 64'h123452B7);
        cycle();

        // Error cases: misaligned J, out-of-range J, bad format, out-of-range I
        set_fields(FMT_J, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3);
        xfer();
        chk("Jodd.err",   64'(b_err), 64'd1);
        chk("Jodd.code",  64'(b_code), 64'd2);
        chk("Jodd.wr_en", 64'(b_wr_en), 64'd0);
        chk("Jodd.ready", 64'(b_ready), 64'd1);
        chk("Jodd.addr",  64'(b_wr_addr), 64'd3);
        set_fields(FMT_J, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0010_0000);
        xfer();
        chk("Jbig.code", 64'(b_code), 64'd1);
        set_fields(3'd6, OPC_OP, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0);
        xfer();
        chk("fmt6.code", 64'(b_code), 64'd3);
        set_fields(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
        xfer();
        chk("I2048.code",  64'(b_code), 64'd1);
        chk("I2048.count", 64'(b_count), 64'd3);
        cycle();

        // Fourth word fills the 2-bit loader
        set_fields(FMT_I, OPC_OP_IMM, 5'd2, 5'd3, 5'd0, 3'd0, 32'd7);
        xfer();
        chk("small.last_addr", 64'(s_wr_addr), 64'd3);
        cycle();
        chk("small.full_set",  64'(s_full), 64'd1);
        chk("small.full_rdy",  64'(s_ready), 64'd0);
        chk("small.full_cnt",  64'(s_count), 64'd4);
        // Fifth word ignored by the full loader
        xfer();
        chk("small.no_write", 64'(s_wr_en), 64'd0);
        cycle();
        chk("small.cnt_hold", 64'(s_count), 64'd4);
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        chk("small.restart_addr", 64'(s_wr_addr), 64'd0);
        chk("small.restart_cnt",  64'(s_count), 64'd0);
        chk("small.restart_rdy",  64'(s_ready), 64'd1);

        // start_i wins over a simultaneous valid_i
        start = 1'b1;
        valid = 1'b1;
        cycle();
        start = 1'b0;
        valid = 1'b0;
        cycle();
        cycle();
        chk("startvalid.wr_en", 64'(b_wr_en), 64'd0);
        cycle();
        chk("startvalid.count", 64'(b_count), 64'd0);

        // Reset during the encode cycle
        set_fields(FMT_R, OPC_OP, 5'd3, 5'd4, 5'd5, 3'd0, 32'd0);
        valid = 1'b1;
        cycle();
        valid = 1'b0;
        rst = 1'b1;
        cycle();
        chk("rstenc.wr_en", 64'(b_wr_en), 64'd0);
        chk("rstenc.data",  64'(b_wr_data), 64'd0);
        chk("rstenc.ready", 64'(b_ready), 64'd1);
        rst = 1'b0;
        cycle();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst   = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 39) == 0);
            valid = ($urandom_range(0, 3) != 0);
            fmt   = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
            op    = 7'($urandom);
            rd    = 5'($urandom);
            rs1   = 5'($urandom);
            rs2   = 5'($urandom);
            f3    = 3'($urandom);
            f7    = 7'($urandom);
            case ($urandom_range(0, 4))
                0: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                1: imm = 32'($urandom);
                2: imm = 32'($urandom) & 32'hFFFF_F000;
                3: imm = 32'($urandom_range(0, 32'h003F_FFFF)) - 32'h0020_0000;
                default: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            endcase
            cycle();
        end
        rst = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
